// File: rtl/klingon_scan_display.sv
// klingon_scan_display: multiplexed DIGITS-wide BCD display, Klingon or decimal glyphs.
// Define KLINGON_LEADING_BLANK_EN to blank leading zero digits (digit 0 always shown).
module klingon_scan_display #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  inc,
  input  logic                  mode,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  wrap
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [4*DIGITS-1:0] held, held_inc;
  logic [DIGITS:0]     carry;
  logic [IW-1:0]       idx;
  logic [PW-1:0]       pre;
  logic [3:0]          cur;
  logic [6:0]          glyph;
  logic                blank, pre_last;
  // ripple increment: 9 and illegal nibbles roll to 0 and carry
  always_comb begin
    carry[0] = 1'b1;
    held_inc = held;
    for (int k = 0; k < DIGITS; k++) begin
      held_inc[4*k +: 4] = !carry[k] ? held[4*k +: 4] :
                           held[4*k +: 4] >= 4'd9 ? 4'd0 : held[4*k +: 4] + 4'd1;
      carry[k+1] = carry[k] && held[4*k +: 4] >= 4'd9;
    end
  end
  assign cur      = held[4*idx +: 4];
  assign pre_last = pre == PW'(PRESCALE - 1);
`ifdef KLINGON_LEADING_BLANK_EN
  assign blank = idx != '0 && (held >> (4*idx)) == '0;
`else
  assign blank = 1'b0;
`endif
  always_comb begin
    glyph = 7'h00;
    case (cur)
      4'd0: glyph = mode ? 7'h3f : 7'h5c;
      4'd1: glyph = mode ? 7'h06 : 7'h30;
      4'd2: glyph = mode ? 7'h5b : 7'h36;
      4'd3: glyph = 7'h4f;
      4'd4: glyph = 7'h66;
      4'd5: glyph = 7'h6d;
      4'd6: glyph = mode ? 7'h7d : 7'h71;
      4'd7: glyph = 7'h07;
      4'd8: glyph = 7'h7f;
      4'd9: glyph = 7'h6f;
      default: glyph = 7'h00;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      held <= '0;
      idx  <= '0;
      pre  <= '0;
      seg  <= 7'h00;
      an   <= '1;
      wrap <= 1'b0;
    end else begin
      held <= load ? din : inc ? held_inc : held;
      wrap <= !load && inc && carry[DIGITS];
      pre  <= pre_last ? '0 : pre + 1'b1;
      if (pre_last) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      an   <= ~(DIGITS'(1) << idx);
      seg  <= blank ? 7'h00 : glyph;
    end
  end
endmodule

// File: tb/tb_klingon_scan_display.sv
// tb_klingon_scan_display: scoreboard bench with a digit-array reference model.
module tb_klingon_scan_display;
  localparam int D = 4;
  localparam int P = 16;
  logic clk = 1'b0;
  logic reset = 1'b1, load = 1'b0, inc = 1'b0, mode = 1'b0;
  logic [4*D-1:0] din = '0;
  logic [6:0] seg;
  logic [D-1:0] an;
  logic wrap;
  always #5 clk = ~clk;
  klingon_scan_display #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .load(load), .din(din), .inc(inc),
    .mode(mode), .seg(seg), .an(an), .wrap(wrap)
  );
  typedef struct packed {
    logic [6:0]   seg;
    logic [D-1:0] an;
    logic         wrap;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int digit[D];
  int cyc = 0;
  function automatic logic [6:0] glyph_of(logic md, int v);
    logic [6:0] kt[10] = '{7'h5c, 7'h30, 7'h36, 7'h4f, 7'h66, 7'h6d, 7'h71, 7'h07, 7'h7f, 7'h6f};
    logic [6:0] dt[10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
    if (v > 9) return 7'h00;
    return md ? dt[v] : kt[v];
  endfunction
  function automatic exp_t predict(logic r, logic l, logic i, logic md);
    exp_t e;
    int k;
    bit all9, lead;
    if (r) return '{seg: 7'h00, an: '1, wrap: 1'b0};
    k = (cyc / P) % D;
    all9 = 1'b1;
    for (int j = 0; j < D; j++) if (digit[j] < 9) all9 = 1'b0;
    lead = 1'b0;
`ifdef KLINGON_LEADING_BLANK_EN
    lead = k != 0;
    for (int j = k; j < D; j++) if (digit[j] != 0) lead = 1'b0;
`endif
    e.seg  = lead ? 7'h00 : glyph_of(md, digit[k]);
    e.an   = '1;
    e.an[k] = 1'b0;
    e.wrap = !l && i && all9;
    return e;
  endfunction
  task automatic step(input logic r, input logic l, input logic i, input logic md,
                      input logic [4*D-1:0] d);
    exp_t e;
    reset = r; load = l; inc = i; mode = md; din = d;
    e = predict(r, l, i, md);
    @(posedge clk);
    q.push_back(e);
    if (r) begin
      foreach (digit[j]) digit[j] = 0;
      cyc = 0;
    end else begin
      cyc++;
      if (l) foreach (digit[j]) digit[j] = int'(d[4*j +: 4]);
      else if (i)
        for (int j = 0; j < D; j++) begin
          if (digit[j] >= 9) digit[j] = 0;
          else begin
            digit[j]++;
            break;
          end
        end
    end
    #1;
  endtask
  task automatic idle(input int n, input logic md);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0, md, '0);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks += 3;
      if (seg !== e.seg) begin
        errors++;
        $display("FAIL seg t=%0t got %h exp %h", $time, seg, e.seg);
      end
      if (an !== e.an) begin
        errors++;
        $display("FAIL an t=%0t got %b exp %b", $time, an, e.an);
      end
      if (wrap !== e.wrap) begin
        errors++;
        $display("FAIL wrap t=%0t got %b exp %b", $time, wrap, e.wrap);
      end
    end
  end
  initial begin
    logic [4*D-1:0] rd;
    logic md;
    foreach (digit[j]) digit[j] = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    idle(4*P, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0912);
    idle(4*P, 1'b1);
    idle(4*P, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h9998);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle(3, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0199);
    step(1'b0, 1'b0, 1'b1, 1'b1, '0);
    idle(4*P, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0042);
    idle(4*P, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h00c0);
    idle(4*P, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h000c);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle(4*P, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
    idle(2*P + 3, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    idle(4*P, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0050);
    idle(4*P, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    idle(4*P, 1'b1);
    md = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      for (int j = 0; j < D; j++)
        rd[4*j +: 4] = ($urandom % 3 == 0) ? 4'd9 : 4'($urandom % 16);
      if ($urandom % 16 == 0) md = ~md;
      step($urandom % 200 == 0, $urandom % 8 == 0, $urandom % 3 == 0, md, rd);
    end
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
